move_sequencer: RTL and testbench
=================================

// Module: move_sequencer
// PURPOSE
//  Sequences all piece-movement operations (left, right, rotate, soft fall, hard drop to bottom)
//  onto the shared move units. All units read and write the single active-piece location/rotation register.
//  Latches key and gravity-tick pulses as pending requests and grants one at a time by fixed priority.
//  Issues a start strobe plus op code, waits for the unit's done handshake, commits its result and
//  flags landing. Sits between the input/timer logic and the move units, under the game FSM.
// PARAMETERS
//  TIMEOUT_CYCLES  256   max cycles in WAIT for unit_done before abort (>=2)
//  SPAWN_LOC       194   reset/respawn value of location_out
// PORTS
//  clk            in   1  system clock, all logic on rising edge
//  rst            in   1  synchronous, active-high reset
//  enable         in   1  game in play; 0 blocks new grants and clears pending
//  respawn        in   1  pulse: load SPAWN_LOC / rotation 0 (new piece)
//  key_left       in   1  one-cycle request pulse
//  key_right      in   1  one-cycle request pulse
//  key_rotate     in   1  one-cycle request pulse
//  key_drop       in   1  one-cycle hard-drop request pulse
//  tick_fall      in   1  one-cycle gravity tick (soft fall one row)
//  op_start       out  1  one-cycle strobe to the selected move unit
//  op_code        out  3  0 NONE,1 LEFT,2 RIGHT,3 ROTATE,4 DOWN,5 TOBOTTOM; held from ISSUE to end of WAIT
//  unit_done      in   1  selected unit finished (sampled only in WAIT)
//  unit_ok        in   1  with unit_done: move legal (1) / blocked (0)
//  unit_location  in   8  with unit_done: resulting location (0..199)
//  unit_rotation  in   2  with unit_done: resulting rotation
//  location_out   out  8  committed piece location
//  rotation_out   out  2  committed piece rotation
//  loc_we         out  1  one-cycle pulse: location_out/rotation_out just updated
//  landed         out  1  one-cycle pulse: piece has come to rest
//  busy           out  1  FSM not in IDLE
//  timeout_err    out  1  sticky: a unit failed to answer; cleared only by rst
// BEHAVIOUR
//  Reset (rst=1 at edge): state IDLE, pending=0, op_start=0, op_code=0, location_out=SPAWN_LOC,
//   rotation_out=0, loc_we=0, landed=0, busy=0, timeout_err=0, wait counter=0. Mid-operation reset aborts; no commit.
//  Pending bits (5): input pulse at edge k sets its bit. Grant clears it. Same-cycle set and clear: set wins.
//   enable=0 clears all pending every cycle.
//  Priority at grant: DROP > FALL > ROTATE > LEFT > RIGHT. Granting TOBOTTOM clears all other pending bits.
//  States:
//   IDLE   : if enable && any pending -> ISSUE, latch op_code of winner, clear its bit.
//   ISSUE  : op_start=1 for exactly this cycle; -> WAIT, counter=0.
//   WAIT   : unit_done=1 -> COMMIT (latch unit_ok/location/rotation);
//            else counter==TIMEOUT_CYCLES-1 -> IDLE, timeout_err=1, op_code=0, no commit; else counter++.
//   COMMIT : if unit_ok: location_out/rotation_out updated at entry, loc_we=1 this cycle.
//            landed=1 this cycle if op==TOBOTTOM, or op==DOWN && !unit_ok. op_code=0; -> IDLE.
//  Latency: request pulse at edge k -> op_start high after edge k+2 (IDLE grant, then ISSUE).
//   unit_done at edge m -> loc_we high after edge m.
//   Back-to-back ops: minimum 4 cycles per op with unit_done one cycle after op_start.
//  unit_done in IDLE/ISSUE/COMMIT is ignored. Blocked moves (unit_ok=0) never change location_out.
//  enable falling mid-op: in-flight op completes and commits normally; no further grants.
//  respawn: in IDLE loads SPAWN_LOC/0 with loc_we=1. In any other state it is ignored; the game FSM
//   only respawns after landed.
//  busy = (state != IDLE), registered with the state.
// TESTING
//  1 key_left pulse, unit_done+unit_ok=1 loc=183 two cycles after op_start -> op_code=1; loc_we one cycle; location_out=183.
//  2 key_left,key_rotate,tick_fall same cycle -> grant order DOWN(4), ROTATE(3), LEFT(1), one op_start each.
//  3 tick_fall, unit_done with unit_ok=0 -> location_out unchanged, loc_we=0, landed=1 one cycle.
//  4 key_drop with key_right pending, unit_loc=4 -> op_code=5, location_out=4, landed=1, RIGHT discarded.
//  5 key_rotate, unit_done never asserted -> after TIMEOUT_CYCLES in WAIT: timeout_err=1 (sticky), IDLE, no loc_we.
//  6 rst=1 during WAIT, then unit_done -> no loc_we; all outputs at reset values; location_out=194.

Source files
------------

// File: rtl/move_sequencer_if.sv
// Handshake bundle between the move sequencer and the shared move units.
// The sequencer (master) issues a start strobe and op code; the selected
// unit (slave) answers with done, legality and the resulting position.
interface move_sequencer_if;
    logic       op_start;
    logic [2:0] op_code;
    logic       unit_done;
    logic       unit_ok;
    logic [7:0] unit_location;
    logic [1:0] unit_rotation;

    modport master (
        output op_start,
        output op_code,
        input  unit_done,
        input  unit_ok,
        input  unit_location,
        input  unit_rotation
    );

    modport slave (
        input  op_start,
        input  op_code,
        output unit_done,
        output unit_ok,
        output unit_location,
        output unit_rotation
    );
endinterface

// File: rtl/move_sequencer.sv
// Move sequencer: latches key and gravity requests, grants one at a time by
// fixed priority (DROP > FALL > ROTATE > LEFT > RIGHT), runs the selected
// move unit through a start/done handshake and commits its result to the
// single active-piece location/rotation register.
module move_sequencer #(
    parameter int         TIMEOUT_CYCLES = 256,
    parameter logic [7:0] SPAWN_LOC      = 8'd194
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   respawn,
    input  logic                   key_left,
    input  logic                   key_right,
    input  logic                   key_rotate,
    input  logic                   key_drop,
    input  logic                   tick_fall,
    move_sequencer_if.master       mv,
    output logic [7:0]             location_out,
    output logic [1:0]             rotation_out,
    output logic                   loc_we,
    output logic                   landed,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [2:0] OP_NONE     = 3'd0;
    localparam logic [2:0] OP_LEFT     = 3'd1;
    localparam logic [2:0] OP_RIGHT    = 3'd2;
    localparam logic [2:0] OP_ROTATE   = 3'd3;
    localparam logic [2:0] OP_DOWN     = 3'd4;
    localparam logic [2:0] OP_TOBOTTOM = 3'd5;

    // Pending-request bit positions
    localparam int P_RIGHT = 0;
    localparam int P_LEFT  = 1;
    localparam int P_ROT   = 2;
    localparam int P_FALL  = 3;
    localparam int P_DROP  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    state_e           state_r, state_nxt_s;
    logic [4:0]       pend_r, pend_nxt_s;
    logic [4:0]       set_s;
    logic [4:0]       win_clr_s;
    logic [2:0]       win_code_s;
    logic             grant_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [2:0]       op_code_r, op_code_nxt_s;
    logic             op_start_r, op_start_nxt_s;
    logic [7:0]       loc_r, loc_nxt_s;
    logic [1:0]       rot_r, rot_nxt_s;
    logic             loc_we_r, loc_we_nxt_s;
    logic             landed_r, landed_nxt_s;
    logic             busy_r;
    logic             tmo_r, tmo_nxt_s;

    assign set_s = {key_drop, tick_fall, key_rotate, key_left, key_right};

    // Priority winner among pending requests and the bits its grant clears
    always_comb begin
        win_code_s = OP_NONE;
        win_clr_s  = 5'b00000;
        if (pend_r[P_DROP]) begin
            win_code_s = OP_TOBOTTOM;
            win_clr_s  = 5'b11111;          // hard drop discards everything else
        end else if (pend_r[P_FALL]) begin
            win_code_s = OP_DOWN;
            win_clr_s  = 5'b01000;
        end else if (pend_r[P_ROT]) begin
            win_code_s = OP_ROTATE;
            win_clr_s  = 5'b00100;
        end else if (pend_r[P_LEFT]) begin
            win_code_s = OP_LEFT;
            win_clr_s  = 5'b00010;
        end else if (pend_r[P_RIGHT]) begin
            win_code_s = OP_RIGHT;
            win_clr_s  = 5'b00001;
        end else begin
            win_code_s = OP_NONE;
            win_clr_s  = 5'b00000;
        end
    end

    // Next-state and next-output logic of the sequencing FSM
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        op_code_nxt_s  = op_code_r;
        op_start_nxt_s = 1'b0;
        loc_nxt_s      = loc_r;
        rot_nxt_s      = rot_r;
        loc_we_nxt_s   = 1'b0;
        landed_nxt_s   = 1'b0;
        tmo_nxt_s      = tmo_r;
        grant_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (enable && (pend_r != 5'b00000)) begin
                    grant_s       = 1'b1;
                    state_nxt_s   = ST_ISSUE;
                    op_code_nxt_s = win_code_s;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
                // New piece: respawn is only honoured while no move is in flight
                if (respawn) begin
                    loc_nxt_s    = SPAWN_LOC;
                    rot_nxt_s    = 2'd0;
                    loc_we_nxt_s = 1'b1;
                end else begin
                    loc_we_nxt_s = 1'b0;
                end
            end
            ST_ISSUE: begin
                op_start_nxt_s = 1'b1;
                cnt_nxt_s      = {CNT_W{1'b0}};
                state_nxt_s    = ST_WAIT;
            end
            ST_WAIT: begin
                if (mv.unit_done) begin
                    state_nxt_s   = ST_COMMIT;
                    op_code_nxt_s = OP_NONE;
                    // Commit at COMMIT entry so loc_we follows unit_done by one edge
                    if (mv.unit_ok) begin
                        loc_nxt_s    = mv.unit_location;
                        rot_nxt_s    = mv.unit_rotation;
                        loc_we_nxt_s = 1'b1;
                    end else begin
                        loc_we_nxt_s = 1'b0;
                    end
                    landed_nxt_s = (op_code_r == OP_TOBOTTOM) ||
                                   ((op_code_r == OP_DOWN) && !mv.unit_ok);
                end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt_s   = ST_IDLE;
                    op_code_nxt_s = OP_NONE;
                    tmo_nxt_s     = 1'b1;
                    cnt_nxt_s     = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s     = cnt_r + CNT_W'(1);
                end
            end
            ST_COMMIT: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                op_code_nxt_s = OP_NONE;
            end
        endcase
    end

    // Pending update: disable clears all, otherwise a new pulse beats a grant clear
    always_comb begin
        if (!enable) begin
            pend_nxt_s = 5'b00000;
        end else if (grant_s) begin
            pend_nxt_s = (pend_r & ~win_clr_s) | set_s;
        end else begin
            pend_nxt_s = pend_r | set_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and registered output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r     <= 5'b00000;
            cnt_r      <= {CNT_W{1'b0}};
            op_code_r  <= OP_NONE;
            op_start_r <= 1'b0;
            loc_r      <= SPAWN_LOC;
            rot_r      <= 2'd0;
            loc_we_r   <= 1'b0;
            landed_r   <= 1'b0;
            busy_r     <= 1'b0;
            tmo_r      <= 1'b0;
        end else begin
            pend_r     <= pend_nxt_s;
            cnt_r      <= cnt_nxt_s;
            op_code_r  <= op_code_nxt_s;
            op_start_r <= op_start_nxt_s;
            loc_r      <= loc_nxt_s;
            rot_r      <= rot_nxt_s;
            loc_we_r   <= loc_we_nxt_s;
            landed_r   <= landed_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            tmo_r      <= tmo_nxt_s;
        end
    end

    assign mv.op_start   = op_start_r;
    assign mv.op_code    = op_code_r;
    assign location_out  = loc_r;
    assign rotation_out  = rot_r;
    assign loc_we        = loc_we_r;
    assign landed        = landed_r;
    assign busy          = busy_r;
    assign timeout_err   = tmo_r;

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: stimulus pushes expected op codes,
// commits and landings into queues; a negedge monitor pops and compares
// whenever the DUT pulses op_start, loc_we or landed.
module tb_move_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       respawn = 1'b0;
    logic       key_left = 1'b0;
    logic       key_right = 1'b0;
    logic       key_rotate = 1'b0;
    logic       key_drop = 1'b0;
    logic       tick_fall = 1'b0;
    logic [7:0] location_out;
    logic [1:0] rotation_out;
    logic       loc_we;
    logic       landed;
    logic       busy;
    logic       timeout_err;

    move_sequencer_if mv();

    move_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .respawn      (respawn),
        .key_left     (key_left),
        .key_right    (key_right),
        .key_rotate   (key_rotate),
        .key_drop     (key_drop),
        .tick_fall    (tick_fall),
        .mv           (mv.master),
        .location_out (location_out),
        .rotation_out (rotation_out),
        .loc_we       (loc_we),
        .landed       (landed),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [2:0]  exp_op_q[$];
    logic [9:0]  exp_we_q[$];     // {location, rotation}
    logic [7:0]  exp_land_q[$];   // location_out while landed pulses

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares every output event against the scoreboard queues
    always @(negedge clk) begin
        if (!rst) begin
            if (mv.op_start === 1'b1) begin
                if (exp_op_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL op_unexpected: got op_code %0d expected no op_start", mv.op_code);
                end else begin
                    chk("op_code", {29'd0, mv.op_code}, {29'd0, exp_op_q.pop_front()});
                end
            end
            if (loc_we === 1'b1) begin
                if (exp_we_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL we_unexpected: got loc %0d expected no loc_we", location_out);
                end else begin
                    chk("commit", {22'd0, location_out, rotation_out}, {22'd0, exp_we_q.pop_front()});
                end
            end
            if (landed === 1'b1) begin
                if (exp_land_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL land_unexpected: got landed at loc %0d expected none", location_out);
                end else begin
                    chk("landed_loc", {24'd0, location_out}, {24'd0, exp_land_q.pop_front()});
                end
            end
        end
    end

    // One-cycle pulse of {drop, fall, rotate, left, right}
    task automatic pulse(input logic [4:0] k);
        @(posedge clk); #1;
        {key_drop, tick_fall, key_rotate, key_left, key_right} = k;
        @(posedge clk); #1;
        {key_drop, tick_fall, key_rotate, key_left, key_right} = 5'b00000;
    endtask

    // Waits (bounded) for op_start; returns cycle stamp and whether it was seen
    task automatic wait_start(output int t_seen, output bit seen);
        seen = 1'b0;
        t_seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (mv.op_start === 1'b1) begin
                seen = 1'b1;
                t_seen = cyc;
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL start_wait: got no op_start expected op_start within 60 cycles");
        end
    endtask

    // Unit model: answer dly edges after op_start rose
    task automatic serve(input logic ok, input logic [7:0] loc, input logic [1:0] rot,
                         input int dly, output int t_seen);
        bit seen;
        wait_start(t_seen, seen);
        if (seen) begin
            repeat (dly - 1) @(posedge clk);
            #1;
            mv.unit_done = 1'b1; mv.unit_ok = ok;
            mv.unit_location = loc; mv.unit_rotation = rot;
            @(posedge clk); #1;
            mv.unit_done = 1'b0; mv.unit_ok = 1'b0;
        end
    endtask

    initial begin
        int t1, t2, t3;
        bit seen;
        mv.unit_done = 1'b0; mv.unit_ok = 1'b0;
        mv.unit_location = 8'd0; mv.unit_rotation = 2'd0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_loc", {24'd0, location_out}, 32'd194);
        chk("rst_rot", {30'd0, rotation_out}, 32'd0);
        chk("rst_opcode", {29'd0, mv.op_code}, 32'd0);
        chk("rst_flags", {27'd0, mv.op_start, loc_we, landed, busy, timeout_err}, 32'd0);

        // enable low: pulse is dropped, nothing granted later
        pulse(5'b00010);
        @(posedge clk); #1 enable = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("disabled_busy", {31'd0, busy}, 32'd0);

        // Test 1: left, done two edges after op_start, commit 183
        exp_op_q.push_back(3'd1);
        exp_we_q.push_back({8'd183, 2'd0});
        pulse(5'b00010);
        serve(1'b1, 8'd183, 2'd0, 2, t1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1_loc", {24'd0, location_out}, 32'd183);

        // Test 2: left+rotate+fall together -> DOWN, ROTATE, LEFT back-to-back
        exp_op_q.push_back(3'd4); exp_we_q.push_back({8'd173, 2'd0});
        exp_op_q.push_back(3'd3); exp_we_q.push_back({8'd173, 2'd1});
        exp_op_q.push_back(3'd1); exp_we_q.push_back({8'd172, 2'd1});
        pulse(5'b01110);
        serve(1'b1, 8'd173, 2'd0, 1, t1);
        serve(1'b1, 8'd173, 2'd1, 1, t2);
        serve(1'b1, 8'd172, 2'd1, 1, t3);
        chk("t2_gap_a", t2 - t1, 32'd4);
        chk("t2_gap_b", t3 - t2, 32'd4);
        repeat (3) @(posedge clk);

        // Test 3: fall blocked -> landed, location unchanged, no loc_we
        exp_op_q.push_back(3'd4);
        exp_land_q.push_back(8'd172);
        pulse(5'b01000);
        serve(1'b0, 8'd99, 2'd3, 1, t1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t3_loc", {24'd0, location_out}, 32'd172);
        chk("t3_rot", {30'd0, rotation_out}, 32'd1);

        // Test 4: drop with right pending -> TOBOTTOM only, right discarded
        exp_op_q.push_back(3'd5);
        exp_we_q.push_back({8'd4, 2'd1});
        exp_land_q.push_back(8'd4);
        pulse(5'b10001);
        serve(1'b1, 8'd4, 2'd1, 1, t1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("t4_loc", {24'd0, location_out}, 32'd4);
        chk("t4_no_right", exp_op_q.size(), 32'd0);

        // Respawn in IDLE reloads the spawn position
        exp_we_q.push_back({8'd194, 2'd0});
        @(posedge clk); #1 respawn = 1'b1;
        @(posedge clk); #1 respawn = 1'b0;
        repeat (2) @(posedge clk);

        // Test 5: rotate never answered -> timeout after 256 WAIT cycles
        exp_op_q.push_back(3'd3);
        pulse(5'b00100);
        wait_start(t1, seen);
        repeat (255) @(posedge clk);
        @(negedge clk);
        chk("t5_pre_tmo", {31'd0, timeout_err}, 32'd0);
        chk("t5_pre_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("t5_tmo", {31'd0, timeout_err}, 32'd1);
        chk("t5_idle", {31'd0, busy}, 32'd0);
        chk("t5_opcode", {29'd0, mv.op_code}, 32'd0);
        chk("t5_loc", {24'd0, location_out}, 32'd194);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t5_sticky", {31'd0, timeout_err}, 32'd1);

        // Test 6: reset during WAIT then late done -> no commit, reset values
        exp_op_q.push_back(3'd1);
        exp_we_q.push_back({8'd150, 2'd2});
        pulse(5'b00010);
        serve(1'b1, 8'd150, 2'd2, 1, t1);
        repeat (3) @(posedge clk);
        exp_op_q.push_back(3'd1);
        pulse(5'b00010);
        wait_start(t1, seen);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        mv.unit_done = 1'b1; mv.unit_ok = 1'b1;
        mv.unit_location = 8'd77; mv.unit_rotation = 2'd3;
        @(posedge clk); #1 mv.unit_done = 1'b0; mv.unit_ok = 1'b0;
        @(negedge clk);
        chk("t6_loc", {24'd0, location_out}, 32'd194);
        chk("t6_rot", {30'd0, rotation_out}, 32'd0);
        chk("t6_flags", {27'd0, mv.op_start, loc_we, landed, busy, timeout_err}, 32'd0);
        chk("t6_opcode", {29'd0, mv.op_code}, 32'd0);
        repeat (4) @(posedge clk);

        @(negedge clk);
        chk("q_op_empty", exp_op_q.size(), 32'd0);
        chk("q_we_empty", exp_we_q.size(), 32'd0);
        chk("q_land_empty", exp_land_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
